// File: rtl/prng_word_packer.sv
// prng_word_packer
//   Samples one tap cell of a Rule 30 CA register on every enabled cycle and packs
//   the tap bits MSB-first into W-bit words. Completed words go into a DEPTH-entry
//   first-word-fall-through FIFO and leave on a valid/ready interface. The first
//   WARMUP enabled cycles after reset are discarded so that the CA can mix.
// Ports
//   clk, reset_n  clock (rising edge), asynchronous active-low reset
//   ca_state      CA register value; only bit TAP is used
//   enable        CA advanced this cycle, so sample the tap
//   clear         synchronous flush of FIFO, shifter and bit count
//   out_ready     sink accepts out_data this cycle
//   out_valid     FIFO non-empty
//   out_data      FIFO head word, or 0 when the FIFO is empty
//   level         FIFO occupancy, 0..DEPTH
//   drop_cnt      saturating count of words lost to a full FIFO
//   warm          1 once warm-up is complete
module prng_word_packer #(
  parameter int N      = 32,
  parameter int TAP    = 16,
  parameter int W      = 8,
  parameter int DEPTH  = 4,
  parameter int WARMUP = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N-1:0]               ca_state,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [15:0]                drop_cnt,
  output logic                       warm
);

  localparam int LW  = $clog2(DEPTH+1);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(W);
  localparam int WUW = $clog2(WARMUP+1);

  localparam logic [LW-1:0]  LVL_FULL = LW'(DEPTH);
  localparam logic [CW-1:0]  BIT_LAST = CW'(W-1);
  localparam logic [WUW-1:0] WU_LAST  = WUW'(WARMUP-1);

  typedef enum logic {WARM_UP, COLLECT} state_t;

  state_t         state;
  logic [WUW-1:0] wu_cnt;

  logic [W-1:0]   shifter;
  logic [CW-1:0]  bit_cnt;
  logic [W-1:0]   mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;

  logic           tap, sample, word_done, pop, push, drop, full;
  logic [W-1:0]   word;
  logic [LW-1:0]  lvl_nxt;
  logic [PW-1:0]  rd_nxt;
  logic [W-1:0]   data_nxt;

  // Warm-up FSM. clear deliberately leaves it alone; only reset restarts warm-up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= WARM_UP;
      wu_cnt <= '0;
      warm   <= 1'b0;
    end else begin
      case (state)
        WARM_UP: if (enable) begin
          if (wu_cnt == WU_LAST) begin
            state <= COLLECT;
            warm  <= 1'b1;
          end else begin
            wu_cnt <= wu_cnt + WUW'(1);
          end
        end
        COLLECT: warm <= 1'b1;
        default: state <= WARM_UP;
      endcase
    end
  end

  always_comb begin
    tap       = ca_state[TAP];
    sample    = (state == COLLECT) && enable && !clear;
    word_done = sample && (bit_cnt == BIT_LAST);
    word      = {shifter[W-2:0], tap};
    full      = (level == LVL_FULL);
    pop       = out_valid && out_ready && !clear;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push      = word_done && (!full || pop);
    drop      = word_done && !push;
    rd_nxt    = pop ? rd_ptr + PW'(1) : rd_ptr;

    lvl_nxt = level;
    case ({push, pop})
      2'b10:   lvl_nxt = level + LW'(1);
      2'b01:   lvl_nxt = level - LW'(1);
      default: lvl_nxt = level;
    endcase

    // Registered head: when the new head slot is the one being written this
    // cycle, the memory does not hold it yet, so forward the incoming word.
    data_nxt = '0;
    if (lvl_nxt != '0) begin
      if (push && (wr_ptr == rd_nxt)) data_nxt = word;
      else                            data_nxt = mem[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shifter   <= '0;
      bit_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      shifter   <= '0;
      bit_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (sample) begin
        shifter <= word;
        bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr    <= rd_nxt;
      level     <= lvl_nxt;
      out_valid <= (lvl_nxt != '0);
      out_data  <= data_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end

endmodule
